mfe_lcd1602_textbuf: RTL and testbench

Character frame buffer and refresh sequencer for the LCD1602. Holds a 2x16 text image written by user logic through a simple byte-write port, runs the power-on init sequence, then streams only modified rows to `mfe_lcd1602_controller` over its `cmd/dat/vld/lwt/ready` word handshake. It sits directly upstream of the controller and replaces hand-written command LUTs in application designs.

---
 rtl/mfe_lcd1602_textbuf.sv | 185 ++++++++++++++++++
 tb/tb_mfe_lcd1602_textbuf.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mfe_lcd1602_textbuf.sv
// LCD1602 2x16 text frame buffer: runs the power-on init sequence, then streams dirty rows to the controller.
// Optional build define MFE_LCD1602_TEXTBUF_CHARMAP_EN remaps data bytes (2D -> B0, >= 80 -> 20).
module mfe_lcd1602_textbuf #(
    parameter logic [7:0] ROW0_ADDR = 8'h80,
    parameter logic [7:0] ROW1_ADDR = 8'hC0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       clr,
    output logic       busy,
    output logic       init_done,
    output logic       ctrl_cmd,
    output logic [7:0] ctrl_dat,
    output logic       ctrl_lwt,
    output logic       ctrl_vld,
    input  logic       ctrl_ready
);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_ADDR,
        ST_CHAR
    } state_t;

    state_t     state;
    logic [7:0] char_mem [32];
    logic [1:0] dirty;
    logic [1:0] dirty_set;
    logic [1:0] dirty_clr;
    logic [1:0] dirty_next;
    logic       row;
    logic [3:0] col;
    logic [2:0] init_idx;
    logic       accept;
    logic       present_ok;
    logic [7:0] char_raw;
    logic [7:0] char_out;
    logic [8:0] init_word;

    assign accept     = ctrl_vld & ctrl_ready;
    assign present_ok = ~ctrl_vld & ctrl_ready;
    assign char_raw   = char_mem[{row, col}];

    // A write or clear landing on the same edge as the ADDR acceptance keeps the row dirty.
    always_comb begin
        dirty_set = 2'b00;
        if (clr) begin
            dirty_set = 2'b11;
        end else if (wr_en) begin
            dirty_set[wr_addr[4]] = 1'b1;
        end
        dirty_clr = 2'b00;
        if (state == ST_ADDR && accept) begin
            dirty_clr[row] = 1'b1;
        end
        dirty_next = (dirty & ~dirty_clr) | dirty_set;
    end

`ifdef MFE_LCD1602_TEXTBUF_CHARMAP_EN
    always_comb begin
        if (char_raw == 8'h2D) begin
            char_out = 8'hB0;
        end else if (char_raw[7]) begin
            char_out = 8'h20;
        end else begin
            char_out = char_raw;
        end
    end
`else
    assign char_out = char_raw;
`endif

    // Init word as {lwt, dat}; only the clear-display command needs the long wait.
    always_comb begin
        case (init_idx)
            3'd0:    init_word = {1'b0, 8'h38};
            3'd1:    init_word = {1'b0, 8'h0C};
            3'd2:    init_word = {1'b1, 8'h01};
            3'd3:    init_word = {1'b0, 8'h06};
            default: init_word = {1'b0, 8'h80};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                char_mem[i] <= 8'h20;
            end
        end else begin
            if (clr) begin
                for (int i = 0; i < 32; i++) begin
                    char_mem[i] <= 8'h20;
                end
            end
            if (wr_en) begin
                char_mem[wr_addr] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            dirty     <= 2'b11;
            row       <= 1'b0;
            col       <= 4'd0;
            init_idx  <= 3'd0;
            ctrl_vld  <= 1'b0;
            ctrl_cmd  <= 1'b0;
            ctrl_dat  <= 8'h00;
            ctrl_lwt  <= 1'b0;
            busy      <= 1'b1;
            init_done <= 1'b0;
        end else begin
            dirty <= dirty_next;
            case (state)
                ST_INIT: begin
                    if (accept) begin
                        ctrl_vld <= 1'b0;
                        if (init_idx == 3'd4) begin
                            init_done <= 1'b1;
                            state     <= ST_IDLE;
                            busy      <= |dirty_next;
                        end else begin
                            init_idx <= init_idx + 3'd1;
                        end
                    end else if (present_ok) begin
                        ctrl_vld <= 1'b1;
                        ctrl_cmd <= 1'b1;
                        ctrl_lwt <= init_word[8];
                        ctrl_dat <= init_word[7:0];
                    end
                end
                ST_IDLE: begin
                    if (dirty[0]) begin
                        row   <= 1'b0;
                        state <= ST_ADDR;
                        busy  <= 1'b1;
                    end else if (dirty[1]) begin
                        row   <= 1'b1;
                        state <= ST_ADDR;
                        busy  <= 1'b1;
                    end else begin
                        busy <= |dirty_next;
                    end
                end
                ST_ADDR: begin
                    if (accept) begin
                        ctrl_vld <= 1'b0;
                        col      <= 4'd0;
                        state    <= ST_CHAR;
                    end else if (present_ok) begin
                        ctrl_vld <= 1'b1;
                        ctrl_cmd <= 1'b1;
                        ctrl_lwt <= 1'b0;
                        ctrl_dat <= row ? ROW1_ADDR : ROW0_ADDR;
                    end
                end
                ST_CHAR: begin
                    // Byte is fetched at presentation so late writes to unsent columns still go out.
                    if (accept) begin
                        ctrl_vld <= 1'b0;
                        if (col == 4'd15) begin
                            state <= ST_IDLE;
                            busy  <= |dirty_next;
                        end else begin
                            col <= col + 4'd1;
                        end
                    end else if (present_ok) begin
                        ctrl_vld <= 1'b1;
                        ctrl_cmd <= 1'b0;
                        ctrl_lwt <= 1'b0;
                        ctrl_dat <= char_out;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_mfe_lcd1602_textbuf.sv
// Directed bench for mfe_lcd1602_textbuf: a controller model logs accepted words and compares them to hand-built lists.
// Honours MFE_LCD1602_TEXTBUF_CHARMAP_EN for the expected data bytes.
module tb_mfe_lcd1602_textbuf;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       clr;
    logic       busy;
    logic       init_done;
    logic       ctrl_cmd;
    logic [7:0] ctrl_dat;
    logic       ctrl_lwt;
    logic       ctrl_vld;
    logic       ctrl_ready;

    int checks = 0;
    int errors = 0;
    int ready_mode = 0;
    int ready_cnt = 0;
    logic [9:0] words [$];
    logic [9:0] exp_q [$];

    mfe_lcd1602_textbuf dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .clr        (clr),
        .busy       (busy),
        .init_done  (init_done),
        .ctrl_cmd   (ctrl_cmd),
        .ctrl_dat   (ctrl_dat),
        .ctrl_lwt   (ctrl_lwt),
        .ctrl_vld   (ctrl_vld),
        .ctrl_ready (ctrl_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Controller model: mode 0 = ready one cycle in four, 1 = always ready, 2 = never ready.
    always @(posedge clk) begin
        #1;
        ready_cnt = ready_cnt + 1;
        case (ready_mode)
            0:       ctrl_ready = ((ready_cnt % 4) == 0);
            1:       ctrl_ready = 1'b1;
            default: ctrl_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (!rst && ctrl_vld && ctrl_ready) begin
            words.push_back({ctrl_cmd, ctrl_lwt, ctrl_dat});
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic c, input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en   = we;
        clr     = c;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
        clr     = 1'b0;
    endtask

    task automatic expWord(input logic c, input logic l, input logic [7:0] d);
        exp_q.push_back({c, l, d});
    endtask

    task automatic expInit();
        expWord(1'b1, 1'b0, 8'h38);
        expWord(1'b1, 1'b0, 8'h0C);
        expWord(1'b1, 1'b1, 8'h01);
        expWord(1'b1, 1'b0, 8'h06);
        expWord(1'b1, 1'b0, 8'h80);
    endtask

    task automatic expBlankRow(input logic [7:0] a);
        expWord(1'b1, 1'b0, a);
        for (int i = 0; i < 16; i++) expWord(1'b0, 1'b0, 8'h20);
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < budget);
        checkOutput({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic waitWords(input string tag, input int count, input int budget);
        int n;
        n = 0;
        while (words.size() < count && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_reached"}, {31'd0, (words.size() >= count)}, 32'd1);
    endtask

    task automatic compareWords(input string tag);
        int n;
        checkOutput({tag, "_count"}, words.size(), exp_q.size());
        n = (words.size() < exp_q.size()) ? words.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_w%0d", tag, i), {22'd0, words[i]}, {22'd0, exp_q[i]});
        end
        words.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] map_2d;
        logic [7:0] map_9a;
        rst        = 1'b1;
        wr_en      = 1'b0;
        clr        = 1'b0;
        wr_addr    = 5'd0;
        wr_data    = 8'd0;
        ctrl_ready = 1'b0;
        ready_mode = 0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_vld",  {31'd0, ctrl_vld},  32'd0);
        checkOutput("rst_cmd",  {31'd0, ctrl_cmd},  32'd0);
        checkOutput("rst_dat",  {24'd0, ctrl_dat},  32'd0);
        checkOutput("rst_lwt",  {31'd0, ctrl_lwt},  32'd0);
        checkOutput("rst_busy", {31'd0, busy},      32'd1);
        checkOutput("rst_init", {31'd0, init_done}, 32'd0);
        words.delete();
        rst = 1'b0;

        // Power-on: init sequence then both blank rows, slow controller
        waitIdle("boot", 3000);
        checkOutput("boot_init_done", {31'd0, init_done}, 32'd1);
        expInit();
        expBlankRow(8'h80);
        expBlankRow(8'hC0);
        compareWords("boot");

        // Single write to row 1 col 3 with an always-ready controller; check the two-cycle latency
        ready_mode = 1;
        repeat (3) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 5'h13, 8'h41);
        checkOutput("lat_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        checkOutput("lat_vld_n1", {31'd0, ctrl_vld}, 32'd0);
        @(negedge clk);
        checkOutput("lat_vld_n2", {31'd0, ctrl_vld}, 32'd1);
        checkOutput("lat_dat_n2", {24'd0, ctrl_dat}, 32'h0000_00C0);
        checkOutput("lat_cmd_n2", {31'd0, ctrl_cmd}, 32'd1);
        waitIdle("wr13", 500);
        expWord(1'b1, 1'b0, 8'hC0);
        for (int i = 0; i < 16; i++) expWord(1'b0, 1'b0, (i == 3) ? 8'h41 : 8'h20);
        compareWords("wr13");

        // Write to row 0 col 8 while row 0 is being refreshed around col 4
        applyStimulus(1'b1, 1'b0, 5'h00, 8'h20);
        waitWords("mid", 5, 200);
        applyStimulus(1'b1, 1'b0, 5'h08, 8'h4D);
        waitIdle("mid", 500);
        for (int p = 0; p < 2; p++) begin
            expWord(1'b1, 1'b0, 8'h80);
            for (int i = 0; i < 16; i++) expWord(1'b0, 1'b0, (i == 8) ? 8'h4D : 8'h20);
        end
        compareWords("mid");

        // Clear with an overlaid write, slow controller
        ready_mode = 0;
        applyStimulus(1'b1, 1'b1, 5'h00, 8'h57);
        waitIdle("clr", 3000);
        expWord(1'b1, 1'b0, 8'h80);
        for (int i = 0; i < 16; i++) expWord(1'b0, 1'b0, (i == 0) ? 8'h57 : 8'h20);
        expBlankRow(8'hC0);
        compareWords("clr");

        // Reset in the middle of a CHAR run restarts from INIT with a blank buffer
        ready_mode = 1;
        applyStimulus(1'b1, 1'b0, 5'h01, 8'h42);
        waitWords("rstmid", 3, 200);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstmid_vld",  {31'd0, ctrl_vld},  32'd0);
        checkOutput("rstmid_busy", {31'd0, busy},      32'd1);
        checkOutput("rstmid_init", {31'd0, init_done}, 32'd0);
        @(negedge clk);
        words.delete();
        rst = 1'b0;
        waitIdle("rstmid", 1000);
        expInit();
        expBlankRow(8'h80);
        expBlankRow(8'hC0);
        compareWords("rstmid");

        // Character map: both writes land before the row is sent
        ready_mode = 2;
        repeat (2) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 5'h00, 8'h2D);
        applyStimulus(1'b1, 1'b0, 5'h01, 8'h9A);
        ready_mode = 1;
        waitIdle("cmap", 500);
`ifdef MFE_LCD1602_TEXTBUF_CHARMAP_EN
        map_2d = 8'hB0;
        map_9a = 8'h20;
`else
        map_2d = 8'h2D;
        map_9a = 8'h9A;
`endif
        expWord(1'b1, 1'b0, 8'h80);
        expWord(1'b0, 1'b0, map_2d);
        expWord(1'b0, 1'b0, map_9a);
        for (int i = 2; i < 16; i++) expWord(1'b0, 1'b0, 8'h20);
        compareWords("cmap");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
